// File: rtl/updown_run_arbiter.sv
// ---------------------------------------------------------------------------
// updown_run_arbiter
//
// Shares one UpDownCount counter between two requesters, A and B. A request
// is a run length plus a direction. The arbiter picks a winner, latches its
// direction onto Swap and its length into the remaining-cycle counter. It
// then holds Enable high for exactly that many cycles and pulses the
// winner's Done. It is the only driver of the counter's Swap and Enable.
//
// Optional feature macro: UDC_ROUND_ROBIN_EN
//   defined   - round-robin arbitration. A one-bit pointer flips in every
//               DONE state and breaks ties when both requesters ask at once.
//   undefined - fixed priority (A beats B), no pointer register.
//
// Ports
//   Clock          in   single rising-edge clock
//   Reset          in   synchronous active-high reset
//   ReqA/DirA/LenA in   requester A: request, direction, run length
//   ReqB/DirB/LenB in   requester B: request, direction, run length
//   GntA/GntB      out  owner of the counter, GRANT through DONE
//   DoneA/DoneB    out  one-cycle pulse at the end of the owner's run
//   Enable         out  counter Enable, high for exactly Len cycles per run
//   Swap           out  counter Swap, changes only on IDLE->GRANT
//   Busy           out  high in every state except IDLE
//   state_dbg      out  current FSM state, for observation only
//
// Handshake: a requester raises Req with stable Dir/Len and keeps Req high
// until its Done pulse. Dir/Len/Req are sampled only in IDLE. After the
// winner is latched they are ignored until the next IDLE.
// ---------------------------------------------------------------------------
module updown_run_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqA,
    input  logic             DirA,
    input  logic [LEN_W-1:0] LenA,
    input  logic             ReqB,
    input  logic             DirB,
    input  logic [LEN_W-1:0] LenB,
    output logic             GntA,
    output logic             GntB,
    output logic             DoneA,
    output logic             DoneB,
    output logic             Enable,
    output logic             Swap,
    output logic             Busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               swap_q, swap_d;
    logic               win_b_q, win_b_d;   // latched winner: 0 = A, 1 = B
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic               done_a_q, done_a_d;
    logic               done_b_q, done_b_d;
    logic               pick_b;

`ifdef UDC_ROUND_ROBIN_EN
    logic               rr_q, rr_d;         // 0 favours A, 1 favours B

    // The pointer decides only on a tie; a lone requester always wins.
    always_comb begin
        pick_b = (ReqA && ReqB) ? rr_q : ReqB;
    end
`else
    // Fixed priority: B wins only when A is not asking.
    always_comb begin
        pick_b = !ReqA;
    end
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        swap_d  = swap_q;
        win_b_d = win_b_q;
`ifdef UDC_ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ReqA || ReqB) begin
                    state_d = ST_GRANT;
                    win_b_d = pick_b;
                    swap_d  = pick_b ? DirB : DirA;
                    rem_d   = pick_b ? LenB : LenA;
                end
            end
            ST_GRANT: begin
                state_d = (rem_q != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Return to IDLE so a finished request is never re-evaluated
                // in the cycle it completes.
                state_d = ST_IDLE;
`ifdef UDC_ROUND_ROBIN_EN
                rr_d    = ~rr_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they line up with
        // the state they describe without any combinational path to ports.
        enable_d = (state_d == ST_RUN);
        busy_d   = (state_d != ST_IDLE);
        gnt_a_d  = busy_d && !win_b_d;
        gnt_b_d  = busy_d &&  win_b_d;
        done_a_d = (state_d == ST_DONE) && !win_b_d;
        done_b_d = (state_d == ST_DONE) &&  win_b_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            swap_q   <= 1'b0;
            win_b_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
`ifdef UDC_ROUND_ROBIN_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            swap_q   <= swap_d;
            win_b_q  <= win_b_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
`ifdef UDC_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign GntA      = gnt_a_q;
    assign GntB      = gnt_b_q;
    assign DoneA     = done_a_q;
    assign DoneB     = done_b_q;
    assign Enable    = enable_q;
    assign Swap      = swap_q;
    assign Busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_updown_run_arbiter.sv
// ---------------------------------------------------------------------------
// tb_updown_run_arbiter
//
// Directed bench for updown_run_arbiter. Each scenario pushes the expected
// per-cycle output words, {GntA,GntB,DoneA,DoneB,Enable,Swap,Busy}, into
// exp_q, starting with the cycle after the request is issued. A separate
// monitor samples on every falling edge. If a word is queued it pops it and
// compares it with the outputs. If the queue is empty the block must be
// quiet: no grant, done, enable or busy.
// ---------------------------------------------------------------------------
module tb_updown_run_arbiter;

  localparam int LEN_W = 4;
  localparam logic [6:0] QUIET_MASK = 7'b1111101; // all but Swap

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req_a, dir_a, req_b, dir_b;
  logic [LEN_W-1:0] len_a, len_b;
  logic             gnt_a, gnt_b, done_a, done_b, enable, swap, busy;
  logic [1:0]       state_dbg;

  updown_run_arbiter #(.LEN_W(LEN_W)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .ReqA      (req_a),
    .DirA      (dir_a),
    .LenA      (len_a),
    .ReqB      (req_b),
    .DirB      (dir_b),
    .LenB      (len_b),
    .GntA      (gnt_a),
    .GntB      (gnt_b),
    .DoneA     (done_a),
    .DoneB     (done_b),
    .Enable    (enable),
    .Swap      (swap),
    .Busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [6:0] mk(input logic ga, input logic gb,
                                    input logic da, input logic db,
                                    input logic en, input logic sw,
                                    input logic bz);
    return {ga, gb, da, db, en, sw, bz};
  endfunction

  // Expected trace of one granted run, from the GRANT cycle to the IDLE
  // cycle after DONE (len + 3 words).
  task automatic push_run(input logic win_b, input logic dir, input int len);
    exp_q.push_back(mk(!win_b, win_b, 1'b0, 1'b0, 1'b0, dir, 1'b1));
    for (int i = 0; i < len; i++)
      exp_q.push_back(mk(!win_b, win_b, 1'b0, 1'b0, 1'b1, dir, 1'b1));
    exp_q.push_back(mk(!win_b, win_b, !win_b, win_b, 1'b0, dir, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dir, 1'b0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [6:0] act;
    logic [6:0] exp;
    cyc = cyc + 1;
    act = {gnt_a, gnt_b, done_a, done_b, enable, swap, busy};
    checks = checks + 1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures = failures + 1;
        $display("FAIL trace cyc=%0d got=%b want=%b (GntA GntB DoneA DoneB Enable Swap Busy)",
                 cyc, act, exp);
      end
    end else if ((act & QUIET_MASK) !== 7'b0) begin
      failures = failures + 1;
      $display("FAIL quiet cyc=%0d got=%b want=%b (Swap ignored)",
               cyc, act & QUIET_MASK, 7'b0);
    end
  end

  // ---------------- driver ----------------
  // Wait n falling edges, then step just past them. Inputs always change
  // mid-cycle, away from the sampling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two edges with ReqA already high: nothing may happen
    // until Reset falls, then GntA rises one cycle later.
    rst = 1'b1;
    req_a = 1'b1; dir_a = 1'b1; len_a = 4'd1;
    req_b = 1'b0; dir_b = 1'b0; len_b = 4'd0;
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    push_run(1'b0, 1'b1, 1);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);
    req_a = 1'b0;
    wait_cyc(3);

    // Single run: A, Dir=1, Len=5.
    req_a = 1'b1; dir_a = 1'b1; len_a = 4'd5;
    push_run(1'b0, 1'b1, 5);
    wait_cyc(7);
    req_a = 1'b0;
    wait_cyc(3);

    // Zero length: B, Dir=0, Len=0. Swap moves from 1 to 0 at the grant.
    req_b = 1'b1; dir_b = 1'b0; len_b = 4'd0;
    push_run(1'b1, 1'b0, 0);
    wait_cyc(2);
    req_b = 1'b0;
    wait_cyc(3);

    // Inputs change mid-run and are ignored: A, Dir=1, Len=4.
    req_a = 1'b1; dir_a = 1'b1; len_a = 4'd4;
    push_run(1'b0, 1'b1, 4);
    wait_cyc(3);
    dir_a = 1'b0; len_a = 4'd9; req_a = 1'b0;
    wait_cyc(6);

    // Contention: both held, Len=3 each. Four DONEs so far leave the
    // round-robin pointer favouring A.
    req_a = 1'b1; dir_a = 1'b1; len_a = 4'd3;
    req_b = 1'b1; dir_b = 1'b0; len_b = 4'd3;
`ifdef UDC_ROUND_ROBIN_EN
    push_run(1'b0, 1'b1, 3);
    push_run(1'b1, 1'b0, 3);
    push_run(1'b0, 1'b1, 3);
    push_run(1'b1, 1'b0, 3);
`else
    push_run(1'b0, 1'b1, 3);
    push_run(1'b0, 1'b1, 3);
    push_run(1'b0, 1'b1, 3);
    push_run(1'b0, 1'b1, 3);
`endif
    wait_cyc(23);
    req_a = 1'b0; req_b = 1'b0;
    wait_cyc(3);

    // Reset in the second RUN cycle: Enable drops, no DoneA, Swap clears.
    req_a = 1'b1; dir_a = 1'b1; len_a = 4'd5;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(7'b0);
    exp_q.push_back(7'b0);
    wait_cyc(3);
    rst = 1'b1; req_a = 1'b0;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(4);

    // Bounded drain of anything still queued.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain got=%0d left want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_run_arbiter.md
# updown_run_arbiter

Shares a single UpDownCount counter between two requesters, A and B. Each requester asks for a run of a given length in a given direction. The arbiter picks one request, drives the counter's Swap and Enable inputs for exactly that run, then signals completion. It sits directly in front of the UpDownCount instance and is the only driver of its Swap and Enable inputs.

## Interface
- LEN_W, 4: width of the run-length fields; the maximum run is 2^LEN_W−1 enabled cycles.
- Clock  in  1  single clock for the whole block; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clock.
- ReqA  in  1  requester A wants a run; held high until DoneA.
- DirA  in  1  A's direction: 0 = Swap low, 1 = Swap high during the run.
- LenA  in  LEN_W  number of Enable-high cycles A requests.
- ReqB, DirB, LenB  in  1/1/LEN_W  the same three inputs for requester B.
- GntA, GntB  out  1  the named requester owns the counter, from the GRANT state through the DONE state; the two are never high together.
- DoneA, DoneB  out  1  one-cycle pulse marking the end of that requester's run.
- Enable  out  1  drives the counter's Enable input.
- Swap  out  1  drives the counter's Swap input.
- Busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, GRANT, RUN, DONE.
- IDLE: if any Req is high, choose a winner and go to GRANT; otherwise stay in IDLE.
- On the IDLE→GRANT transition:
  - latch the winner's Dir into Swap;
  - latch the winner's Len into the remaining-cycle counter Rem (LEN_W bits);
  - latch the winner's identity.
- After latching, changes on Dir, Len or Req are ignored until the run ends.
- GRANT: lasts one cycle; Swap has settled and Enable is low. Next state is RUN if Rem≠0, otherwise DONE.
- RUN: Enable is high and Rem decrements each cycle. When Rem reaches 1, the next state is DONE.
- DONE: lasts one cycle; the winner's Done pulses and Enable is low. Next state is IDLE.
  - A request is never re-evaluated in the same cycle it completes, so it cannot win again until the next IDLE.
- Swap holds its last latched value in IDLE and after the run. It changes only on the IDLE→GRANT transition.
- If Req drops mid-run, the run still completes and Done still pulses.
- Winner selection depends on UDC_ROUND_ROBIN_EN (see Configuration).

## Timing
- Reset values: state IDLE, Rem 0, and Enable, Swap, GntA, GntB, DoneA, DoneB and Busy all 0. The round-robin pointer favours A.
- A Reset asserted in any state takes effect at the next edge:
  - the run is aborted with Enable low and no Done pulse;
  - requesters must re-request.
- Request latency: Req is sampled high in IDLE at cycle 0.
  - Cycle 1 is GRANT: Gnt and Busy go high and Swap is valid.
  - Enable is high in cycles 2 to Len+1.
  - Done pulses in cycle Len+2.
  - The state is IDLE again at cycle Len+3.
- Len = 0: GRANT in cycle 1, Done in cycle 2, Enable never asserts.
- The minimum spacing between the start of two consecutive grants is Len+3 cycles.
- Enable is high for exactly Len cycles per grant, with no gaps.

## Configuration
- UDC_ROUND_ROBIN_EN defined:
  - round-robin arbitration; the pointer flips to the other requester in each DONE state;
  - when ReqA and ReqB are both high in IDLE, the requester the pointer favours wins;
  - when only one Req is high, that requester wins regardless of the pointer.
- UDC_ROUND_ROBIN_EN undefined:
  - fixed priority, A always beats B;
  - no pointer register is built;
  - B can be starved while A keeps requesting.

## Test plan
- Reset: hold Reset high for 2 cycles with ReqA=1 → all outputs 0 and no grant; GntA rises 1 cycle after Reset falls.
- Single run: ReqA=1, DirA=1, LenA=5 → GntA and Swap=1 from cycle 1, Enable high in cycles 2–6, DoneA in cycle 7, Busy low from cycle 8.
- Zero length: ReqB=1, LenB=0 → GntB in cycle 1, DoneB in cycle 2, Enable never high.
- Contention: ReqA and ReqB held high with LenA=LenB=3.
  - With UDC_ROUND_ROBIN_EN: grants go A, B, A, B, each 6 cycles apart.
  - Without it: A is granted every time and GntB never asserts.
- Input changes mid-run: during A's RUN (Len=4), change DirA to 0, set LenA=9 and drop ReqA → Swap stays 1, Enable is high for exactly 4 cycles and DoneA still pulses.
- Reset mid-run: assert Reset in the 2nd RUN cycle → Enable is 0 at the next edge, no DoneA pulse, and Swap returns to 0.
